rot_arbiter: RTL and testbench
==============================

Name: rot_arbiter

Overview:
- Shares one combinational 2**N-bit rotator among NREQ requesters.
- Each requester side uses a valid/ready handshake. Requesters are served in round-robin order.
- The rotated result is registered into a single output slot. The output side has its own valid/ready handshake with backpressure and carries the ID of the requester that was served.
- Sits between the lab's requester ports (switch/UART command front ends) and the shared rotate datapath.

Parameters:
- N, 3, log2 of data width; data width W = 2**N, rotate amount width N.
- NREQ, 4, number of requesters (2..8).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request i presents a valid operation.
- req_ready  out  NREQ  request i accepted this cycle (transfer = valid & ready).
- req_a  in  NREQ x W  operand per requester.
- req_amt  in  NREQ x N  rotate amount per requester.
- req_lr  in  NREQ  direction per requester: 1 = rotate left, 0 = rotate right.
- rsp_valid  out  1  output slot holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_y  out  W  rotated result.
- rsp_id  out  clog2(NREQ)  index of the served requester.
- op_count  out  CNTW  number of accepted requests, wrapping.

Behaviour:
- Reset (asynchronous, active-high): rsp_valid=0, rsp_y=0, rsp_id=0, op_count=0, round-robin pointer ptr=0. While reset is high, req_ready=0.
- Rotation is a true rotation with no bits lost.
  - lr=1: y = (a << amt) | (a >> (W-amt)).
  - lr=0: y = (a >> amt) | (a << (W-amt)).
  - amt=0 gives y=a.
- load = ~rsp_valid | rsp_ready, meaning the output slot is free this cycle or is being drained this cycle.
- Grant is combinational.
  - Search indices ptr, ptr+1, ... mod NREQ and pick the first i with req_valid[i].
  - At most one req_ready bit is high at a time.
  - req_ready[i] = load & grant[i].
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer on granted index g (load & req_valid[g]), at the next edge:
  - rsp_y <= rot(req_a[g], req_amt[g], req_lr[g]).
  - rsp_id <= g.
  - rsp_valid <= 1.
  - ptr <= (g+1) mod NREQ.
  - op_count <= op_count+1, wrapping at 2**CNTW.
- Latency: the result is visible exactly 1 cycle after the accepting edge. Throughput is 1 operation per cycle while rsp_ready=1.
- load=1 with no valid request: rsp_valid <= 0. ptr and rsp_y hold; rsp_y is don't-care when rsp_valid=0 but is held for debug.
- Backpressure: while rsp_valid=1 and rsp_ready=0:
  - the slot holds rsp_y and rsp_id stable;
  - all req_ready=0;
  - ptr holds.
- Simultaneous drain and accept (rsp_valid=1, rsp_ready=1, request valid): the slot is overwritten in the same edge with no bubble.
- Requester protocol: once req_valid[i]=1, requester i holds req_a/amt/lr stable until it sees req_ready[i]. The arbiter tolerates valid dropping without acceptance; it simply re-arbitrates.
- Fairness: a continuously-valid requester is granted within NREQ accepted transfers.
- NREQ not a power of two: ptr wraps from NREQ-1 to 0. Indices ≥ NREQ are never granted.
- Reset mid-operation: an in-flight result is discarded, rsp_valid falls immediately (asynchronously), and ptr returns to 0.

Decomposition:
- Package rot_pkg holds:
  - localparams W=2**N and IDW=$clog2(NREQ) (minimum 1);
  - function rotl/rotr for reference use by the bench.
- One combinational sub-module, rot_unit (a, amt, lr -> y), instantiated once on the granted operands through an NREQ:1 mux.
- Arbiter and output register stay in rot_arbiter.

Test Plan (N=3, W=8, NREQ=4):
- Single requester, rotate left: req0 a=8'h96, amt=3, lr=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_y=8'hB4, rsp_id=0, op_count=1.
- Single requester, rotate right and zero amount:
  - req2 a=8'h96, amt=3, lr=0 -> rsp_y=8'hD2, rsp_id=2.
  - then amt=0 -> rsp_y=8'h96.
- Round robin: all four requests valid and held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles; each req_ready pulses once per 4 cycles.
- Backpressure: result pending with rsp_ready=0 for 5 cycles while req1 and req3 are valid -> req_ready=0 throughout, rsp_y/rsp_id stable; after rsp_ready=1, the next grant goes to the requester after the last served one.
- Mixed traffic: 256 random operations compared against rot_pkg rotl/rotr -> zero mismatches, and op_count = 256 mod 2**16.
- Asynchronous reset asserted mid-stream, between clock edges -> rsp_valid=0 immediately, op_count=0; after release, req3 and req0 both valid -> req0 is granted first (ptr=0).

Source files
------------

// File: rtl/rot_arbiter_pkg.sv
// Shared constants and reference rotate functions for the rotator arbiter.
package rot_pkg;

    // Default configuration used by the arbiter and its testbench.
    localparam int PKG_N    = 3;
    localparam int PKG_NREQ = 4;
    localparam int PKG_CNTW = 16;

    localparam int W   = 2 ** PKG_N;
    localparam int IDW = (PKG_NREQ > 1) ? $clog2(PKG_NREQ) : 1;

    // Reference rotate-left written with the textbook shift pair.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] a, input logic [PKG_N-1:0] amt);
        logic [W-1:0] l;
        logic [W-1:0] r;
        l = a << amt;
        r = (amt == '0) ? '0 : (a >> (W - int'(amt)));
        return l | r;
    endfunction

    // Reference rotate-right written with the textbook shift pair.
    function automatic logic [W-1:0] rotr(input logic [W-1:0] a, input logic [PKG_N-1:0] amt);
        logic [W-1:0] l;
        logic [W-1:0] r;
        r = a >> amt;
        l = (amt == '0) ? '0 : (a << (W - int'(amt)));
        return l | r;
    endfunction

endpackage

// File: rtl/rot_arbiter_rot_unit.sv
// Combinational 2**N-bit rotator; no bits are lost in either direction.
module rot_unit
    import rot_pkg::*;
#(
    parameter  int N = PKG_N,
    localparam int DW = 2 ** N
) (
    input  logic [DW-1:0] i_a,
    input  logic [N-1:0]  i_amt,
    input  logic          i_lr,
    output logic [DW-1:0] o_y
);

    logic [2*DW-1:0] w_dbl;
    logic [2*DW-1:0] w_shl;
    logic [2*DW-1:0] w_shr;

    // Shifting the operand concatenated with itself yields the rotation in one half.
    always_comb begin
        w_dbl = {i_a, i_a};
        w_shl = w_dbl << i_amt;
        w_shr = w_dbl >> i_amt;
        o_y   = i_lr ? w_shl[2*DW-1:DW] : w_shr[DW-1:0];
    end

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one rotator among NREQ valid/ready requesters,
// with a single registered output slot carrying result and requester ID.
module rot_arbiter
    import rot_pkg::*;
#(
    parameter  int N    = PKG_N,
    parameter  int NREQ = PKG_NREQ,
    parameter  int CNTW = PKG_CNTW,
    localparam int DW   = 2 ** N,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][DW-1:0]  req_a,
    input  logic [NREQ-1:0][N-1:0]   req_amt,
    input  logic [NREQ-1:0]          req_lr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_y,
    output logic [IW-1:0]            rsp_id,
    output logic [CNTW-1:0]          op_count
);

    logic [IW-1:0]   r_ptr;
    logic            r_valid;
    logic [DW-1:0]   r_y;
    logic [IW-1:0]   r_id;
    logic [CNTW-1:0] r_count;

    logic            w_load;
    logic            w_found;
    logic [IW-1:0]   w_gidx;
    logic            w_xfer;
    logic [DW-1:0]   w_a;
    logic [N-1:0]    w_amt;
    logic            w_lr;
    logic [DW-1:0]   w_y;
    logic [IW-1:0]   w_ptr_nxt;

    assign w_load = ~r_valid | rsp_ready;

    // Round-robin search: indices at or above ptr first, then wrap to those below.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i >= 32'(r_ptr))) begin
                w_found = 1'b1;
                w_gidx  = IW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i < 32'(r_ptr))) begin
                w_found = 1'b1;
                w_gidx  = IW'(i);
            end
        end
    end

    // Operand mux onto the shared rotator and handshake outputs.
    always_comb begin
        w_a       = req_a[w_gidx];
        w_amt     = req_amt[w_gidx];
        w_lr      = req_lr[w_gidx];
        w_xfer    = w_load & w_found & ~reset;
        w_ptr_nxt = (w_gidx == IW'(NREQ - 1)) ? '0 : (w_gidx + 1'b1);
        req_ready = w_xfer ? (NREQ'(1) << w_gidx) : '0;
    end

    rot_unit #(.N(N)) u_rot (
        .i_a   (w_a),
        .i_amt (w_amt),
        .i_lr  (w_lr),
        .o_y   (w_y)
    );

    // Output slot, round-robin pointer and completed-operation counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_y     <= w_y;
            r_id    <= w_gidx;
            r_ptr   <= w_ptr_nxt;
            r_count <= r_count + 1'b1;
        end else if (w_load) begin
            r_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_y     = r_y;
    assign rsp_id    = r_id;
    assign op_count  = r_count;

endmodule

// File: tb/tb_rot_arbiter.sv
// Directed and randomised checks for rot_arbiter (N=3, NREQ=4).
module tb_rot_arbiter;
    import rot_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [3:0][7:0] req_a;
    logic [3:0][2:0] req_amt;
    logic [3:0]      req_lr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_y;
    logic [1:0]      rsp_id;
    logic [15:0]     op_count;

    int checks = 0;
    int failures = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    rot_arbiter #(.N(3), .NREQ(4), .CNTW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_amt   (req_amt),
        .req_lr    (req_lr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [2:0] amt;
        logic       lr;
        logic [7:0] y;
    } vec_t;

    vec_t        tbl[8];
    int          exp_cnt;
    logic [7:0]  rr_y[4];

    // Random-phase model state.
    logic        m_valid;
    logic [7:0]  m_y;
    logic [1:0]  m_id;
    int          m_ptr;
    int          acc;
    int          g;
    logic        m_load;
    logic [3:0]  exp_rdy;

    initial begin
        tbl[0] = '{0, 8'h96, 3'd3, 1'b1, 8'hB4};
        tbl[1] = '{2, 8'h96, 3'd3, 1'b0, 8'hD2};
        tbl[2] = '{2, 8'h96, 3'd0, 1'b0, 8'h96};
        tbl[3] = '{1, 8'h01, 3'd1, 1'b1, 8'h02};
        tbl[4] = '{3, 8'h80, 3'd7, 1'b0, 8'h01};
        tbl[5] = '{0, 8'h81, 3'd1, 1'b1, 8'h03};
        tbl[6] = '{1, 8'hA5, 3'd4, 1'b1, 8'h5A};
        tbl[7] = '{3, 8'h01, 3'd1, 1'b0, 8'h80};
        rr_y[0] = 8'h11; rr_y[1] = 8'h44; rr_y[2] = 8'hCC; rr_y[3] = 8'h22;

        reset     = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_amt   = '0;
        req_lr    = '0;
        rsp_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_y", 32'(rsp_y), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        #9;
        reset     = 1'b0;
        req_valid = '0;
        exp_cnt   = 0;
        step();

        // Single-requester vectors, back to back.
        for (int v = 0; v < 8; v++) begin
            req_valid = 4'b0001 << tbl[v].idx;
            req_a[tbl[v].idx]   = tbl[v].a;
            req_amt[tbl[v].idx] = tbl[v].amt;
            req_lr[tbl[v].idx]  = tbl[v].lr;
            rsp_ready = 1'b1;
            #1;
            chk("vec_ready", 32'(req_ready), 32'(4'b0001 << tbl[v].idx));
            step();
            exp_cnt++;
            req_valid = '0;
            chk("vec_valid", 32'(rsp_valid), 32'd1);
            chk("vec_y", 32'(rsp_y), 32'(tbl[v].y));
            chk("vec_id", 32'(rsp_id), 32'(tbl[v].idx));
            chk("vec_count", 32'(op_count), 32'(exp_cnt));
        end

        // Idle drain: slot empties, data held.
        step();
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk("idle_y_held", 32'(rsp_y), 32'h80);

        // Round robin with all four held valid.
        for (int i = 0; i < 4; i++) begin
            req_a[i]   = 8'h11 * (i + 1);
            req_amt[i] = 3'(i);
            req_lr[i]  = ((i % 2) == 1);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            step();
            exp_cnt++;
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_y", 32'(rsp_y), 32'(rr_y[k % 4]));
        end

        // Backpressure: slot holds req0 result for 5 cycles.
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            step();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_y", 32'(rsp_y), 32'h11);
        end
        chk("bp_count", 32'(op_count), 32'(exp_cnt));
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_ready1", 32'(req_ready), 32'b0010);
        step();
        exp_cnt++;
        chk("bp_rel_id1", 32'(rsp_id), 32'd1);
        chk("bp_rel_y1", 32'(rsp_y), 32'h44);
        #1;
        chk("bp_rel_ready3", 32'(req_ready), 32'b1000);
        step();
        exp_cnt++;
        chk("bp_rel_id3", 32'(rsp_id), 32'd3);
        chk("bp_rel_y3", 32'(rsp_y), 32'h22);
        chk("bp_rel_count", 32'(op_count), 32'(exp_cnt));
        req_valid = '0;

        // Fresh start for the random phase.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_valid = 1'b0; m_y = '0; m_id = '0; m_ptr = 0; acc = 0;

        for (int cyc = 0; cyc < 4000 && acc < 256; cyc++) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                req_a[i]   = 8'($urandom);
                req_amt[i] = 3'($urandom);
                req_lr[i]  = 1'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            m_load = !m_valid || rsp_ready;
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
            exp_rdy = (m_load && g >= 0) ? (4'b0001 << g) : 4'b0000;
            chk("rand_ready", 32'(req_ready), 32'(exp_rdy));
            if (m_load && g >= 0) begin
                m_valid = 1'b1;
                m_y     = req_lr[g] ? rotl(req_a[g], req_amt[g]) : rotr(req_a[g], req_amt[g]);
                m_id    = 2'(g);
                m_ptr   = (g + 1) % 4;
                acc++;
            end else if (m_load) begin
                m_valid = 1'b0;
            end
            step();
            chk("rand_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rand_y", 32'(rsp_y), 32'(m_y));
                chk("rand_id", 32'(rsp_id), 32'(m_id));
            end
        end
        chk("rand_budget", 32'(acc), 32'd256);
        chk("rand_count", 32'(op_count), 32'd256);

        // Asynchronous reset between edges while traffic is flowing.
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        step();
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_count", 32'(op_count), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_id", 32'(rsp_id), 32'd0);
        reset     = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b0001);
        step();
        chk("post_rst_valid", 32'(rsp_valid), 32'd1);
        chk("post_rst_id", 32'(rsp_id), 32'd0);
        chk("post_rst_count", 32'(op_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
